// File: rtl/time_keeper.sv
`default_nettype none
// ============================================================================
// Module   : time_keeper
// Brief    : Real-time clock core. Divides the board clock into a 1 Hz tick
//            and keeps 24 h binary time (hh:mm:ss). A set mode lets buttons
//            adjust hours and minutes. Outputs feed the 7-segment stage.
// Revision : 1.0 - initial release
// ============================================================================
module time_keeper #(
  parameter int TICKS_PER_SECOND = 50000000
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       setMode,
  input  logic       incMinutes,
  input  logic       incHours,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [5:0] hours,
  output logic       secondTick,
  output logic       blink
);

  localparam int            PW       = $clog2(TICKS_PER_SECOND);
  localparam logic [PW-1:0] TERMINAL = PW'(TICKS_PER_SECOND - 1);
  localparam logic [PW-1:0] HALF     = PW'(TICKS_PER_SECOND / 2);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [PW-1:0] prescaler_nxt;
  logic [5:0]    seconds_nxt;
  logic [5:0]    minutes_nxt;
  logic [5:0]    hours_nxt;
  logic          tick;

  logic set_meta, set_sync;
  logic min_meta, min_sync, min_prev;
  logic hr_meta, hr_sync, hr_prev;
  logic min_rise, hr_rise;

  // Two-flop synchronizers for the asynchronous buttons, plus one delay flop
  // on each increment button so a press is seen as a single rising edge.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      set_meta <= 1'b0;
      set_sync <= 1'b0;
      min_meta <= 1'b0;
      min_sync <= 1'b0;
      min_prev <= 1'b0;
      hr_meta  <= 1'b0;
      hr_sync  <= 1'b0;
      hr_prev  <= 1'b0;
    end else begin
      set_meta <= setMode;
      set_sync <= set_meta;
      min_meta <= incMinutes;
      min_sync <= min_meta;
      min_prev <= min_sync;
      hr_meta  <= incHours;
      hr_sync  <= hr_meta;
      hr_prev  <= hr_sync;
    end
  end

  assign min_rise = min_sync & ~min_prev;
  assign hr_rise  = hr_sync & ~hr_prev;

  // Next-state time arithmetic. The synchronized setMode level decides the
  // behaviour directly, so an edge coinciding with entry into set mode is
  // honoured and the prescaler restarts from 0 on the first run cycle.
  always_comb begin
    prescaler_nxt = prescaler;
    seconds_nxt   = seconds;
    minutes_nxt   = minutes;
    hours_nxt     = hours;
    tick          = 1'b0;
    if (set_sync) begin
      prescaler_nxt = '0;
      seconds_nxt   = '0;
      if (min_rise) begin
        minutes_nxt = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
      end
      if (hr_rise) begin
        hours_nxt = (hours == 6'd23) ? 6'd0 : hours + 6'd1;
      end
    end else if (prescaler == TERMINAL) begin
      prescaler_nxt = '0;
      tick          = 1'b1;
      if (seconds == 6'd59) begin
        seconds_nxt = 6'd0;
        if (minutes == 6'd59) begin
          minutes_nxt = 6'd0;
          hours_nxt   = (hours == 6'd23) ? 6'd0 : hours + 6'd1;
        end else begin
          minutes_nxt = minutes + 6'd1;
        end
      end else begin
        seconds_nxt = seconds + 6'd1;
      end
    end else begin
      prescaler_nxt = prescaler + PW'(1);
    end
  end

  // RUN/SET state machine with registered time, tick and blink outputs.
  // blink is computed from the next prescaler value so that it tracks the
  // prescaler register itself and is high on every secondTick cycle.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_RUN;
      prescaler  <= '0;
      seconds    <= 6'd0;
      minutes    <= 6'd0;
      hours      <= 6'd0;
      secondTick <= 1'b0;
      blink      <= 1'b1;
    end else begin
      case (state)
        ST_RUN:  if (set_sync)  state <= ST_SET;
        ST_SET:  if (!set_sync) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
      prescaler  <= prescaler_nxt;
      seconds    <= seconds_nxt;
      minutes    <= minutes_nxt;
      hours      <= hours_nxt;
      secondTick <= tick;
      blink      <= (prescaler_nxt < HALF);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_keeper
// Brief    : Self-checking bench for time_keeper with a cycle scoreboard and
//            directed checks for reset, rollover, set mode and blink.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_keeper;

  localparam int TPS = 4;

  logic       clock      = 1'b0;
  logic       resetN     = 1'b1;
  logic       setMode    = 1'b0;
  logic       incMinutes = 1'b0;
  logic       incHours   = 1'b0;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [5:0] hours;
  logic       secondTick;
  logic       blink;

  int n_checks = 0;
  int n_errors = 0;

  time_keeper #(.TICKS_PER_SECOND(TPS)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .setMode    (setMode),
    .incMinutes (incMinutes),
    .incHours   (incHours),
    .seconds    (seconds),
    .minutes    (minutes),
    .hours      (hours),
    .secondTick (secondTick),
    .blink      (blink)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference model state
  int         m_pre, m_sec, m_min, m_hr;
  bit         m_tick, m_blink;
  bit         m_s1, m_s2, m_a1, m_a2, m_ad, m_b1, m_b2, m_bd;
  bit         m_set, m_me, m_he;
  logic [19:0] exp_q[$];
  logic [19:0] sb_exp;

  // Model steps on every clock edge and pushes the expected outputs.
  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      m_pre = 0; m_sec = 0; m_min = 0; m_hr = 0;
      m_tick = 1'b0; m_blink = 1'b1;
      m_s1 = 0; m_s2 = 0; m_a1 = 0; m_a2 = 0; m_ad = 0; m_b1 = 0; m_b2 = 0; m_bd = 0;
      exp_q.delete();
    end else begin
      m_set = m_s2;
      m_me  = m_a2 & ~m_ad;
      m_he  = m_b2 & ~m_bd;
      m_s2 = m_s1; m_s1 = setMode;
      m_ad = m_a2; m_a2 = m_a1; m_a1 = incMinutes;
      m_bd = m_b2; m_b2 = m_b1; m_b1 = incHours;
      m_tick = 1'b0;
      if (m_set) begin
        m_pre = 0;
        m_sec = 0;
        if (m_me) m_min = (m_min + 1) % 60;
        if (m_he) m_hr = (m_hr + 1) % 24;
      end else if (m_pre == TPS - 1) begin
        m_pre  = 0;
        m_tick = 1'b1;
        m_sec  = m_sec + 1;
        if (m_sec == 60) begin
          m_sec = 0;
          m_min = m_min + 1;
          if (m_min == 60) begin
            m_min = 0;
            m_hr  = (m_hr + 1) % 24;
          end
        end
      end else begin
        m_pre = m_pre + 1;
      end
      m_blink = (m_pre < TPS / 2);
      exp_q.push_back({6'(m_sec), 6'(m_min), 6'(m_hr), m_tick, m_blink});
    end
  end

  // Scoreboard: compare DUT outputs against the model on the falling edge.
  always @(negedge clock) begin
    if (resetN && exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      check_value("cycle", {12'd0, seconds, minutes, hours, secondTick, blink}, {12'd0, sb_exp});
    end
  end

  task automatic pulse_buttons(input bit do_min, input bit do_hr, input int n, input int hold);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (do_min) incMinutes = 1'b1;
      if (do_hr)  incHours   = 1'b1;
      repeat (hold) @(negedge clock);
      incMinutes = 1'b0;
      incHours   = 1'b0;
      repeat (2) @(negedge clock);
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int found;
  int prev_sec;
  int ticks;

  initial begin
    // Asynchronous reset, no clock edge required
    #1 resetN = 1'b0;
    #1;
    check_value("reset_sec",   32'(seconds), 0);
    check_value("reset_min",   32'(minutes), 0);
    check_value("reset_hr",    32'(hours), 0);
    check_value("reset_tick",  32'(secondTick), 0);
    check_value("reset_blink", 32'(blink), 1);
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      check_value("tick_early", 32'(secondTick), 0);
    end
    @(posedge clock); #1;
    check_value("first_tick", 32'(secondTick), 1);
    check_value("first_sec",  32'(seconds), 1);

    // Enter set mode: seconds forced to 0, no ticks
    repeat (10) @(negedge clock);
    setMode = 1'b1;
    repeat (3) @(negedge clock);
    check_value("set_sec_zero", 32'(seconds), 0);
    ticks = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (secondTick) ticks++;
    end
    check_value("set_no_tick", ticks, 0);
    check_value("set_blink", 32'(blink), 1);

    // Minute wrap without hour carry, hour wrap
    pulse_buttons(1'b1, 1'b0, 61, 2);
    check_value("min61", 32'(minutes), 1);
    check_value("min61_hr", 32'(hours), 0);
    pulse_buttons(1'b0, 1'b1, 25, 2);
    check_value("hr25", 32'(hours), 1);

    // Held button increments once
    pulse_buttons(1'b1, 1'b0, 1, 50);
    check_value("hold_min", 32'(minutes), 2);

    // Pin edge to minutes change latency
    @(negedge clock);
    incMinutes = 1'b1;
    @(posedge clock); #1;
    check_value("lat_c1", 32'(minutes), 2);
    @(posedge clock); #1;
    check_value("lat_c2", 32'(minutes), 2);
    @(posedge clock); #1;
    check_value("lat_c3", 32'(minutes), 3);
    @(negedge clock);
    incMinutes = 1'b0;
    repeat (3) @(negedge clock);

    // Preset 23:59, then simultaneous press wraps both
    pulse_buttons(1'b0, 1'b1, 22, 2);
    pulse_buttons(1'b1, 1'b0, 56, 2);
    check_value("pre_hr", 32'(hours), 23);
    check_value("pre_min", 32'(minutes), 59);
    pulse_buttons(1'b1, 1'b1, 1, 2);
    check_value("both_min", 32'(minutes), 0);
    check_value("both_hr", 32'(hours), 0);

    // Preset 23:59 again and run through midnight
    pulse_buttons(1'b0, 1'b1, 23, 2);
    pulse_buttons(1'b1, 1'b0, 59, 2);
    @(negedge clock);
    setMode = 1'b0;
    found = 0;
    prev_sec = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      if (secondTick && seconds == 6'd0) begin
        found = 1;
        break;
      end
      if (secondTick) prev_sec = int'(seconds);
    end
    check_value("roll_found", found, 1);
    check_value("roll_prev_sec", prev_sec, 59);
    check_value("roll_min", 32'(minutes), 0);
    check_value("roll_hr", 32'(hours), 0);

    // Run mode ignores increment buttons
    pulse_buttons(1'b0, 1'b1, 3, 2);
    check_value("mask_hr", 32'(hours), 0);
    pulse_buttons(1'b1, 1'b0, 2, 2);
    check_value("mask_min", 32'(minutes), 0);

    // Blink pattern aligned to secondTick
    found = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (secondTick) begin
        found = 1;
        break;
      end
    end
    check_value("blink_found", found, 1);
    for (int k = 0; k < 8; k++) begin
      check_value("blink", 32'(blink), (k % 4 < 2) ? 1 : 0);
      check_value("blink_tick", 32'(secondTick), (k % 4 == 0) ? 1 : 0);
      if (k < 7) begin
        @(posedge clock); #1;
      end
    end

    // Set 12:34, run to :56, then reset mid-count
    @(negedge clock);
    setMode = 1'b1;
    repeat (3) @(negedge clock);
    pulse_buttons(1'b0, 1'b1, 12, 2);
    pulse_buttons(1'b1, 1'b0, 34, 2);
    @(negedge clock);
    setMode = 1'b0;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      if (seconds == 6'd56) begin
        found = 1;
        break;
      end
    end
    check_value("mid_found", found, 1);
    check_value("mid_min", 32'(minutes), 34);
    check_value("mid_hr", 32'(hours), 12);
    #2 resetN = 1'b0;
    #1;
    check_value("mid_reset_sec",   32'(seconds), 0);
    check_value("mid_reset_min",   32'(minutes), 0);
    check_value("mid_reset_hr",    32'(hours), 0);
    check_value("mid_reset_tick",  32'(secondTick), 0);
    check_value("mid_reset_blink", 32'(blink), 1);
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    repeat (12) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
